// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_e;

   localparam int BIT_CYCLES   = 10416;
   localparam int FRAME_CYCLES = 10 * BIT_CYCLES;

   // Grant index width; a single requester still needs a 1-bit index.
   function automatic int req_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and serializer-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   localparam int REQ_W = uart_pkg::req_w(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_done;
   logic [REQ_W-1:0]     grant_id;
   logic                 busy;
   logic                 timeout_err;

   modport slave (
      input  req_valid, req_data, req_last, tx_done,
      output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
   );

   modport master (
      output req_valid, req_data, req_last, tx_done,
      input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int REQ_W   = req_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [REQ_W-1:0]   ptr_i,
   output logic [REQ_W-1:0]   winner_o,
   output logic               any_valid_o
);

   // Scan from the farthest offset down so the nearest request overwrites last.
   always_comb begin
      winner_o    = '0;
      any_valid_o = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
            winner_o    = REQ_W'((int'(ptr_i) + k) % NUM_REQ);
            any_valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte streams: round-robin,
// message lock until req_last, inter-frame gap and tx_done / lock watchdog.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 131072
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int REQ_W   = req_w(NUM_REQ);
   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   state_e             state_q;
   logic [REQ_W-1:0]   grant_q;
   logic [REQ_W-1:0]   rr_ptr_q;
   logic [7:0]         tx_data_q;
   logic               last_q;
   logic               locked_q;
   logic               tx_start_q;
   logic [NUM_REQ-1:0] req_ready_q;
   logic               busy_q;
   logic               timeout_err_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [CNT_W-1:0]   cnt_d;
   logic [REQ_W-1:0]   rr_next_d;
   logic [NUM_REQ-1:0] eligible;
   logic [REQ_W-1:0]   winner;
   logic               any_valid;
   logic               wd_hit;
   logic               gap_hit;
   logic [7:0]         req_byte [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
      assign req_byte[g] = bus.req_data[8*g +: 8];
   end

   // While a message holds the lock only its owner may be picked.
   assign eligible  = locked_q ? (bus.req_valid & onehot(grant_q)) : bus.req_valid;
   assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign rr_next_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
   assign wd_hit    = (int'(cnt_q) + 1 >= TIMEOUT_CYCLES);
   assign gap_hit   = (int'(cnt_q) + 1 >= GAP_CYCLES);

   rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_rr (
      .req_i       (eligible),
      .ptr_i       (rr_ptr_q),
      .winner_o    (winner),
      .any_valid_o (any_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         tx_data_q     <= '0;
         last_q        <= 1'b0;
         locked_q      <= 1'b0;
         tx_start_q    <= 1'b0;
         req_ready_q   <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         tx_start_q  <= 1'b0;
         req_ready_q <= '0;
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  state_q   <= START;
                  grant_q   <= winner;
                  tx_data_q <= req_byte[winner];
                  last_q    <= bus.req_last[winner];
               end else if (locked_q) begin
                  // Owner went quiet mid-message: give the bus back after the limit.
                  if (wd_hit) begin
                     timeout_err_q <= 1'b1;
                     locked_q      <= 1'b0;
                     rr_ptr_q      <= rr_next_d;
                     cnt_q         <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            START: begin
               state_q     <= WAIT_DONE;
               tx_start_q  <= 1'b1;
               req_ready_q <= onehot(grant_q);
               busy_q      <= 1'b1;
               cnt_q       <= '0;
            end
            WAIT_DONE: begin
               if (bus.tx_done) begin
                  state_q <= GAP;
                  cnt_q   <= '0;
                  if (last_q) begin
                     locked_q <= 1'b0;
                     rr_ptr_q <= rr_next_d;
                  end else begin
                     locked_q <= 1'b1;
                  end
               end else if (wd_hit) begin
                  state_q       <= GAP;
                  cnt_q         <= '0;
                  timeout_err_q <= 1'b1;
                  locked_q      <= 1'b0;
                  rr_ptr_q      <= rr_next_d;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            GAP: begin
               if (gap_hit) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.grant_id    = grant_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut_a uses the default watchdog, dut_b a 64-cycle watchdog.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(4)) a_if ();
   uart_tx_arbiter_if #(.NUM_REQ(4)) b_if ();

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(131072)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   // uart_tx models: tx_done 100 (a) or 20 (b) cycles after the tx_start cycle
   int a_dcnt = 0;
   int b_dcnt = 0;
   bit b_model_on = 1'b1;
   int a_ready_pulses = 0;

   always @(posedge clk) begin
      a_if.tx_done <= 1'b0;
      if (a_if.tx_start) a_dcnt <= 99;
      else if (a_dcnt > 0) begin
         a_dcnt <= a_dcnt - 1;
         if (a_dcnt == 1) a_if.tx_done <= 1'b1;
      end
   end

   always @(posedge clk) begin
      b_if.tx_done <= 1'b0;
      if (b_if.tx_start && b_model_on) b_dcnt <= 19;
      else if (b_dcnt > 0) begin
         b_dcnt <= b_dcnt - 1;
         if (b_dcnt == 1) b_if.tx_done <= 1'b1;
      end
   end

   always @(negedge clk) a_ready_pulses += $countones(a_if.req_ready);

   task automatic clear_inputs();
      a_if.req_valid = '0; a_if.req_data = '0; a_if.req_last = '0;
      b_if.req_valid = '0; b_if.req_data = '0; b_if.req_last = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_start(input bit use_b, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = use_b ? b_if.tx_start : a_if.tx_start;
      end
   endtask

   // Counts cycles, from the current one, until busy reads low.
   task automatic wait_idle(input bit use_b, input int budget, output int cycles, output bit seen);
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < budget) begin
         if (!(use_b ? b_if.busy : a_if.busy)) seen = 1'b1;
         else begin
            cycles++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({a_if.req_ready, a_if.tx_start, a_if.tx_data, a_if.grant_id, a_if.busy, a_if.timeout_err} !== 17'h0) begin
         n_fail++;
         $display("FAIL reset_a_outputs: got %h, expected 0",
                  {a_if.req_ready, a_if.tx_start, a_if.tx_data, a_if.grant_id, a_if.busy, a_if.timeout_err});
      end
      n_checks++;
      if ({b_if.req_ready, b_if.tx_start, b_if.tx_data, b_if.grant_id, b_if.busy, b_if.timeout_err} !== 17'h0) begin
         n_fail++;
         $display("FAIL reset_b_outputs: got %h, expected 0",
                  {b_if.req_ready, b_if.tx_start, b_if.tx_data, b_if.grant_id, b_if.busy, b_if.timeout_err});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int width;
      bit idle;
      @(negedge clk);
      a_if.req_data[15:8] = 8'h55;
      a_if.req_last       = 4'b0010;
      a_if.req_valid      = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (a_if.tx_start !== 1'b0) begin
         n_fail++; $display("FAIL single_early_start: got %b, expected 0", a_if.tx_start);
      end
      @(negedge clk);
      n_checks++;
      if (a_if.tx_start !== 1'b1) begin
         n_fail++; $display("FAIL single_start_latency: got %b, expected 1", a_if.tx_start);
      end
      n_checks++;
      if (a_if.tx_data !== 8'h55) begin
         n_fail++; $display("FAIL single_tx_data: got %h, expected 55", a_if.tx_data);
      end
      n_checks++;
      if (a_if.req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL single_req_ready: got %b, expected 0010", a_if.req_ready);
      end
      n_checks++;
      if (a_if.grant_id !== 2'd1) begin
         n_fail++; $display("FAIL single_grant: got %0d, expected 1", a_if.grant_id);
      end
      a_if.req_valid = '0;
      wait_idle(1'b0, 1000, width, idle);
      n_checks++;
      if (!idle || width != 117) begin
         n_fail++; $display("FAIL single_busy_width: got %0d, expected 117", width);
      end
   endtask

   task automatic test_fairness();
      int base;
      int width;
      bit seen;
      bit idle;
      logic [1:0] exp_g;
      pulse_reset();
      base = a_ready_pulses;
      a_if.req_data  = 32'h13121110;
      a_if.req_last  = 4'b1111;
      a_if.req_valid = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         exp_g = 2'(f % 4);
         wait_start(1'b0, 400, seen);
         n_checks++;
         if (!seen || a_if.grant_id !== exp_g) begin
            n_fail++; $display("FAIL fair_grant_%0d: got %0d (seen=%b), expected %0d", f, a_if.grant_id, seen, exp_g);
         end
         n_checks++;
         if (a_if.req_ready !== (4'b0001 << exp_g) || a_if.tx_data !== (8'h10 + 8'(exp_g))) begin
            n_fail++; $display("FAIL fair_frame_%0d: ready=%b data=%h, expected ready=%b data=%h",
                               f, a_if.req_ready, a_if.tx_data, 4'b0001 << exp_g, 8'h10 + 8'(exp_g));
         end
         if (f == 4) a_if.req_valid = '0;
      end
      wait_idle(1'b0, 400, width, idle);
      n_checks++;
      if (a_ready_pulses - base != 5) begin
         n_fail++; $display("FAIL fair_ready_count: got %0d, expected 5", a_ready_pulses - base);
      end
   endtask

   task automatic test_lock();
      int width;
      bit seen;
      bit idle;
      @(negedge clk);
      a_if.req_data  = {8'h33, 8'hA3, 16'h0000};
      a_if.req_last  = 4'b1000;
      a_if.req_valid = 4'b1100;
      wait_start(1'b0, 400, seen);
      n_checks++;
      if (!seen || a_if.grant_id !== 2'd2 || a_if.tx_data !== 8'hA3) begin
         n_fail++; $display("FAIL lock_first: grant=%0d data=%h, expected grant=2 data=a3", a_if.grant_id, a_if.tx_data);
      end
      a_if.req_data[23:16] = 8'h5A;
      a_if.req_last[2]     = 1'b1;
      wait_start(1'b0, 400, seen);
      n_checks++;
      if (!seen || a_if.grant_id !== 2'd2 || a_if.tx_data !== 8'h5A) begin
         n_fail++; $display("FAIL lock_second: grant=%0d data=%h, expected grant=2 data=5a", a_if.grant_id, a_if.tx_data);
      end
      a_if.req_valid[2] = 1'b0;
      wait_start(1'b0, 400, seen);
      n_checks++;
      if (!seen || a_if.grant_id !== 2'd3 || a_if.tx_data !== 8'h33) begin
         n_fail++; $display("FAIL lock_release: grant=%0d data=%h, expected grant=3 data=33", a_if.grant_id, a_if.tx_data);
      end
      a_if.req_valid = '0;
      wait_idle(1'b0, 400, width, idle);
   endtask

   task automatic test_frame_watchdog();
      int width;
      bit seen;
      bit idle;
      pulse_reset();
      b_model_on = 1'b0;
      b_if.req_data  = {16'h0000, 8'hC1, 8'hC0};
      b_if.req_last  = 4'b0011;
      b_if.req_valid = 4'b0011;
      wait_start(1'b1, 400, seen);
      n_checks++;
      if (!seen || b_if.grant_id !== 2'd0) begin
         n_fail++; $display("FAIL fwd_first_grant: got %0d, expected 0", b_if.grant_id);
      end
      // tx_start is START+1, so START+64 and START+65 are 63 and 64 cycles on
      repeat (63) @(negedge clk);
      n_checks++;
      if (b_if.timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL fwd_err_early: got %b, expected 0", b_if.timeout_err);
      end
      @(negedge clk);
      n_checks++;
      if (b_if.timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL fwd_err_set: got %b, expected 1", b_if.timeout_err);
      end
      wait_start(1'b1, 400, seen);
      n_checks++;
      if (!seen || b_if.grant_id !== 2'd1 || b_if.tx_data !== 8'hC1) begin
         n_fail++; $display("FAIL fwd_next_grant: grant=%0d data=%h, expected grant=1 data=c1", b_if.grant_id, b_if.tx_data);
      end
      n_checks++;
      if (b_if.timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL fwd_err_sticky: got %b, expected 1", b_if.timeout_err);
      end
      b_if.req_valid = '0;
      wait_idle(1'b1, 400, width, idle);
      b_model_on = 1'b1;
   endtask

   task automatic test_lock_watchdog();
      int width;
      int n;
      bit seen;
      bit idle;
      pulse_reset();
      b_if.req_data  = {16'h0000, 8'hD1, 8'hD0};
      b_if.req_last  = 4'b0000;
      b_if.req_valid = 4'b0001;
      wait_start(1'b1, 400, seen);
      n_checks++;
      if (!seen || b_if.grant_id !== 2'd0 || b_if.tx_data !== 8'hD0) begin
         n_fail++; $display("FAIL lwd_first: grant=%0d data=%h, expected grant=0 data=d0", b_if.grant_id, b_if.tx_data);
      end
      b_if.req_last  = 4'b0010;
      b_if.req_valid = 4'b0010;
      wait_idle(1'b1, 400, width, idle);
      n_checks++;
      if (!idle || b_if.timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL lwd_err_before: idle=%b err=%b, expected idle=1 err=0", idle, b_if.timeout_err);
      end
      // 64 locked idle cycles, one arbitration cycle, one START cycle
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         seen = b_if.tx_start;
      end
      n_checks++;
      if (!seen || n != 66 || b_if.grant_id !== 2'd1) begin
         n_fail++; $display("FAIL lwd_grant_delay: cycles=%0d grant=%0d, expected cycles=66 grant=1", n, b_if.grant_id);
      end
      n_checks++;
      if (b_if.timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL lwd_err_set: got %b, expected 1", b_if.timeout_err);
      end
      b_if.req_valid = '0;
      wait_idle(1'b1, 400, width, idle);
   endtask

   task automatic test_reset_mid_frame();
      int width;
      int n;
      bit seen;
      bit idle;
      @(negedge clk);
      a_if.req_data  = {16'h0000, 8'h77, 8'h00};
      a_if.req_last  = 4'b0010;
      a_if.req_valid = 4'b0010;
      wait_start(1'b0, 400, seen);
      a_if.req_valid = '0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({a_if.req_ready, a_if.tx_start, a_if.tx_data, a_if.grant_id, a_if.busy, a_if.timeout_err} !== 17'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs_%0d: got %h, expected 0", i,
                     {a_if.req_ready, a_if.tx_start, a_if.tx_data, a_if.grant_id, a_if.busy, a_if.timeout_err});
         end
      end
      rst = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         seen = a_if.tx_done;
      end
      n_checks++;
      if (!seen || a_if.busy !== 1'b0 || a_if.tx_start !== 1'b0) begin
         n_fail++; $display("FAIL midrst_stale_done: seen=%b busy=%b start=%b, expected seen=1 busy=0 start=0",
                            seen, a_if.busy, a_if.tx_start);
      end
      a_if.req_data  = {24'h000000, 8'hA3};
      a_if.req_last  = 4'b0001;
      a_if.req_valid = 4'b0001;
      wait_start(1'b0, 400, seen);
      n_checks++;
      if (!seen || a_if.grant_id !== 2'd0 || a_if.tx_data !== 8'hA3) begin
         n_fail++; $display("FAIL midrst_new_frame: grant=%0d data=%h, expected grant=0 data=a3", a_if.grant_id, a_if.tx_data);
      end
      a_if.req_valid = '0;
      wait_idle(1'b0, 400, width, idle);
      n_checks++;
      if (!idle || width != 117) begin
         n_fail++; $display("FAIL midrst_busy_width: got %0d, expected 117", width);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_lock();
      test_frame_watchdog();
      test_lock_watchdog();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish within 2 ms");
      $fatal(1);
   end

endmodule
